key_debounce: RTL and testbench
===============================

# key_debounce

Debounces and edge-detects the board's push buttons and produces clean, single-cycle press and release events in the system clock domain. It sits between the raw button pins and every consumer of button input, such as the seven-segment enable toggle. Consumers use the `press`/`any_press` pulses as clock enables instead of clocking logic on raw button edges.

## Interface
- `N`, 6: number of buttons.
- `DEBOUNCE_CYCLES`, 1_000_000: stable-input cycles required before a state change is accepted; 10 ms at 100 MHz; minimum 2.
- `LONG_CYCLES`, 100_000_000: hold cycles counted from acceptance of a press before `long_press` fires; only meaningful with `KEY_LONG_PRESS_EN`; minimum 2.
- `ACTIVE_LOW`, 0: 1 means a pressed button drives the pin low.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `swb`  in  N  raw button pins; asynchronous, may bounce.
- `level`  out  N  debounced pressed state; 1 means pressed.
- `press`  out  N  one-cycle pulse when a press is accepted.
- `release`  out  N  one-cycle pulse when a release is accepted.
- `long_press`  out  N  one-cycle pulse once per hold after `LONG_CYCLES`.
- `any_press`  out  1  registered OR of `press`, aligned with `press`.

## Operation
- **Normalisation:** each pin is XORed with `ACTIVE_LOW`, so 1 always means pressed.
- **Synchronisation:** each pin passes through a 2-FF synchroniser. The synchroniser output is called `s`.
- **Per-channel FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Each channel has its own counter `cnt`.
- **IDLE:**
  - `s`=1 → PRESS_WAIT, `cnt`←0.
- **PRESS_WAIT:**
  - `s`=0 → IDLE. A bounce discards progress.
  - `s`=1 and `cnt`≠`DEBOUNCE_CYCLES`−1 → `cnt`++.
  - `s`=1 and `cnt`=`DEBOUNCE_CYCLES`−1 → PRESSED, `press`=1 for one cycle, `level`←1, hold counter cleared.
- **PRESSED:**
  - `s`=0 → RELEASE_WAIT, `cnt`←0.
  - Otherwise the hold counter advances (macro only).
- **RELEASE_WAIT:** mirror of PRESS_WAIT.
  - `s`=1 → PRESSED. `level` stays 1 and no pulse is emitted.
  - `s`=0 and `cnt`=`DEBOUNCE_CYCLES`−1 → IDLE, `release`=1 for one cycle, `level`←0.
- **Counters:** width is `$clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1)`. Counters saturate and never wrap.
- **Independence:** channels are fully independent. Simultaneous presses on several buttons give simultaneous `press` bits and a single `any_press` cycle.
- **Event ordering:** `press` and `release` are never high together on one channel. At least `DEBOUNCE_CYCLES` cycles separate consecutive events on a channel.

## Timing
- **Reset values:** all outputs 0, synchronisers 0, every FSM in IDLE, all counters 0.
- **Reset mid-operation:** the block returns to IDLE immediately and emits no pulse on deassertion. A button still held after reset is accepted as a fresh press after a full debounce.
- **Press latency:** the pin changes before edge 0 and stays stable. `s` rises at edge 2 and PRESS_WAIT is entered at edge 3 with `cnt`=0. `press`, `level` and `any_press` are high after edge `DEBOUNCE_CYCLES`+3.
- **Release latency:** identical, `DEBOUNCE_CYCLES`+3 edges.
- **Pulse registration:** all pulses are registered outputs, exactly one cycle wide, with no combinational path from `swb`.
- **Long press:** `long_press` rises `LONG_CYCLES` edges after `press` if the channel remains in PRESSED or RELEASE_WAIT throughout. It fires at most once per hold and re-arms after `release`.

## Configuration
- **Macro:** `KEY_LONG_PRESS_EN`.
- **Defined:** the hold counters and `long_press` logic are built.
- **Undefined:** the `long_press` port remains and is tied to 0. No hold counters are synthesised.

## Structure
- **Shared package `key_pkg`:**
  - FSM state typedef with encoding IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11.
  - Default constants `KEY_DEBOUNCE_DEFAULT` and `KEY_LONG_DEFAULT`.
- **Sub-module `key_debounce_ch`:** one channel containing the synchroniser, FSM and counters. It is instantiated N times by a generate loop.
- **Top level:** the top adds only the `any_press` OR register.

## Test plan
Bench parameters: `N`=6, `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=8, macro defined.
- **Clean press:** `swb[0]` rises before edge 0 → `press[0]`=1 and `any_press`=1 only during the cycle after edge 7, and `level[0]`=1 from edge 7.
- **Bounce rejection:** `swb[1]` high for 3 cycles, low for 1, then stable high → no pulse until 7 edges after the final rise.
- **Release:** `swb[0]` falls after hold → `release[0]` pulse 7 edges later and `level[0]`=0. A 2-cycle low glitch during hold produces no pulses.
- **Simultaneous press:** `swb`=6'b100001 in one cycle → `press`=6'b100001 and a single-cycle `any_press`.
- **Long press:** hold `swb[2]` → `long_press[2]` pulse exactly 8 edges after `press[2]`. No second pulse while held, and a new pulse follows after release and re-press.
- **Reset mid-operation:** `rst_n` low during PRESS_WAIT with the button held → all outputs 0 immediately. After deassertion, `press` arrives `DEBOUNCE_CYCLES`+3 edges later.
- **Active-low polarity:** with `ACTIVE_LOW`=1, pins idle high produce no events.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and defaults for the push-button debouncer.
// The optional long-press feature is selected with the KEY_LONG_PRESS_EN macro.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b10,
      RELEASE_WAIT = 2'b11
   } key_state_e;

   localparam int KEY_DEBOUNCE_DEFAULT = 1_000_000;
   localparam int KEY_LONG_DEFAULT     = 100_000_000;

   function automatic int key_cnt_width(input int deb_cycles, input int long_cycles);
      int largest;
      if (deb_cycles > long_cycles) begin
         largest = deb_cycles;
      end else begin
         largest = long_cycles;
      end
      return $clog2(largest + 1);
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: polarity register, 2-FF synchroniser, debounce FSM and,
// with KEY_LONG_PRESS_EN defined, the hold counter that produces long_press.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
   parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic press,
   output logic release_pulse,
   output logic long_press,
   output logic press_next
);

   localparam int            CW       = key_cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   logic          in_q, in_d;
   logic          meta_q;
   logic          s_q;
   key_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;

   // Next-state logic; a bounce during either wait state discards progress.
   always_comb begin
      in_d      = pin ^ ACTIVE_LOW;
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (s_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         PRESS_WAIT: begin
            if (!s_q) begin
               state_d = IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
               press_d = 1'b1;
               level_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         PRESSED: begin
            if (!s_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = {CW{1'b0}};
            end else begin
               state_d = PRESSED;
            end
         end
         RELEASE_WAIT: begin
            if (s_q) begin
               state_d = PRESSED;
            end else if (cnt_q == DEB_LAST) begin
               state_d   = IDLE;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CW{1'b0}};
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q      <= 1'b0;
         meta_q    <= 1'b0;
         s_q       <= 1'b0;
         state_q   <= IDLE;
         cnt_q     <= {CW{1'b0}};
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         in_q      <= in_d;
         meta_q    <= in_q;
         s_q       <= meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

`ifdef KEY_LONG_PRESS_EN
   localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_SAT  = CW'(LONG_CYCLES);

   logic [CW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   // Hold time keeps running through RELEASE_WAIT and parks at HOLD_SAT so it fires once.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (press_d) begin
         hold_d = {CW{1'b0}};
      end else if (((state_q == PRESSED) || (state_q == RELEASE_WAIT)) && (hold_q < HOLD_SAT)) begin
         hold_d = hold_q + CW'(1);
         if (hold_q == HOLD_LAST) begin
            long_d = 1'b1;
         end else begin
            long_d = 1'b0;
         end
      end else begin
         hold_d = hold_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= {CW{1'b0}};
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_press = long_q;
`else
   assign long_press = 1'b0;
`endif

   assign level         = level_q;
   assign press         = press_q;
   assign release_pulse = release_q;
   assign press_next    = press_d;

endmodule

// File: rtl/key_debounce.sv
// N independent debounce channels plus the registered any_press OR.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
   import key_pkg::*;
#(
   parameter int N               = 6,
   parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
   parameter int LONG_CYCLES     = KEY_LONG_DEFAULT,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] swb,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] long_press,
   output logic         any_press
);

   logic [N-1:0] press_next;
   logic         any_press_q, any_press_d;

   for (genvar g = 0; g < N; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW != 0)
      ) u_ch (
         .clk           (clk),
         .rst_n         (rst_n),
         .pin           (swb[g]),
         .level         (level[g]),
         .press         (press[g]),
         .release_pulse (release_pulse[g]),
         .long_press    (long_press[g]),
         .press_next    (press_next[g])
      );
   end

   // Built from the channels' next-press terms so it lands in the same cycle as press.
   always_comb begin
      any_press_d = |press_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_press_q <= 1'b0;
      end else begin
         any_press_q <= any_press_d;
      end
   end

   assign any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed timing scenarios plus random pin activity
// checked against a run-length reference model of the accepted button state.
module tb_key_debounce;

   localparam int N = 6;
   localparam int D = 4;
   localparam int L = 8;
`ifdef KEY_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] swb   = '0;
   logic [N-1:0] swb2  = '1;
   logic [N-1:0] level, press, rel, lng;
   logic         any;
   logic [N-1:0] level2, press2, rel2, lng2;
   logic         any2;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   key_debounce #(.N(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(0)) dut (
      .clk(clk), .rst_n(rst_n), .swb(swb), .level(level), .press(press),
      .release_pulse(rel), .long_press(lng), .any_press(any)
   );

   key_debounce #(.N(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut_al (
      .clk(clk), .rst_n(rst_n), .swb(swb2), .level(level2), .press(press2),
      .release_pulse(rel2), .long_press(lng2), .any_press(any2)
   );

   // Reference model: pin history (3-edge input latency), run length of disagreement
   // with the accepted level, and hold age since the last accepted press.
   logic [N-1:0] h0, h1, h2, m_lvl, m_press, m_rel, m_long;
   int           run [N];
   int           age [N];
   bit           fired [N];

   task automatic model_reset();
      h0 = '0; h1 = '0; h2 = '0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
         run[i] = 0; age[i] = 0; fired[i] = 1'b0;
      end
   endtask

   task automatic model_edge(input logic [N-1:0] pin);
      logic [N-1:0] v;
      v = h2; h2 = h1; h1 = h0; h0 = pin;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
         if (m_lvl[i] && !fired[i]) begin
            age[i]++;
            if (age[i] == L) begin
               m_long[i] = 1'b1;
               fired[i]  = 1'b1;
            end
         end
         if (v[i] != m_lvl[i]) begin
            run[i]++;
            if (run[i] == D + 1) begin
               run[i]   = 0;
               m_lvl[i] = v[i];
               if (v[i]) begin
                  m_press[i] = 1'b1;
                  age[i]     = 0;
                  fired[i]   = 1'b0;
               end else begin
                  m_rel[i] = 1'b1;
               end
            end
         end else begin
            run[i] = 0;
         end
      end
      if (!LONG_EN) m_long = '0;
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_edge(swb);
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      swb   = '0;
      swb2  = '1;
      model_reset();
      #1;
      tests++;
      if ({level, press, rel, lng, any} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b lng=%b any=%b want all 0", level, press, rel, lng, any);
      end
      tests++;
      if ({level2, press2, rel2, lng2, any2} !== '0) begin
         fails++;
         $display("FAIL reset_outputs_al: got lvl=%b prs=%b want all 0", level2, press2);
      end
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_clean_press();
      swb[0] = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         step();
         tests++;
         if (press[0] !== (k == 7) || any !== (k == 7)) begin
            fails++;
            $display("FAIL clean_press edge %0d: press0=%b any=%b want %b", k, press[0], any, (k == 7));
         end
         tests++;
         if (level[0] !== (k >= 7)) begin
            fails++;
            $display("FAIL clean_level edge %0d: got %b want %b", k, level[0], (k >= 7));
         end
      end
   endtask

   task automatic test_bounce();
      for (int k = 0; k <= 14; k++) begin
         swb[1] = (k != 3);
         step();
         tests++;
         if (press[1] !== (k == 11) || level[1] !== (k >= 11)) begin
            fails++;
            $display("FAIL bounce edge %0d: press1=%b level1=%b want %b/%b", k, press[1], level[1], (k == 11), (k >= 11));
         end
      end
   endtask

   task automatic test_release();
      for (int k = 0; k <= 11; k++) begin
         swb[0] = !(k == 0 || k == 1);
         step();
         tests++;
         if (rel[0] !== 1'b0 || press[0] !== 1'b0 || level[0] !== 1'b1) begin
            fails++;
            $display("FAIL glitch edge %0d: rel0=%b press0=%b level0=%b want 0/0/1", k, rel[0], press[0], level[0]);
         end
      end
      swb[0] = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         step();
         tests++;
         if (rel[0] !== (k == 7) || level[0] !== (k < 7) || press[0] !== 1'b0) begin
            fails++;
            $display("FAIL release edge %0d: rel0=%b level0=%b want %b/%b", k, rel[0], level[0], (k == 7), (k < 7));
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] exp;
      swb = 6'b100001;
      for (int k = 0; k <= 10; k++) begin
         step();
         exp = (k == 7) ? 6'b100001 : 6'b000000;
         tests++;
         if (press !== exp || any !== (k == 7)) begin
            fails++;
            $display("FAIL simultaneous edge %0d: press=%b any=%b want %b/%b", k, press, any, exp, (k == 7));
         end
      end
   endtask

   task automatic test_long_press();
      for (int pass = 0; pass < 2; pass++) begin
         swb[2] = 1'b1;
         for (int k = 0; k <= 40; k++) begin
            step();
            tests++;
            if (press[2] !== (k == 7) || lng[2] !== (LONG_EN && k == 15)) begin
               fails++;
               $display("FAIL long_press pass %0d edge %0d: press2=%b long2=%b want %b/%b",
                        pass, k, press[2], lng[2], (k == 7), (LONG_EN && k == 15));
            end
         end
         swb[2] = 1'b0;
         for (int k = 0; k <= 10; k++) begin
            step();
            tests++;
            if (rel[2] !== (k == 7) || lng[2] !== 1'b0) begin
               fails++;
               $display("FAIL long_release edge %0d: rel2=%b long2=%b want %b/0", k, rel[2], lng[2], (k == 7));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [N-1:0] exp;
      swb[0] = 1'b1;
      for (int k = 0; k < 10; k++) step();
      swb[3] = 1'b1;
      for (int k = 0; k < 5; k++) step();
      rst_n = 1'b0;
      #1;
      tests++;
      if ({level, press, rel, lng, any} !== '0) begin
         fails++;
         $display("FAIL reset_mid: got lvl=%b prs=%b rel=%b lng=%b any=%b want all 0", level, press, rel, lng, any);
      end
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k <= 10; k++) begin
         step();
         exp = (k == 7) ? 6'b001001 : 6'b000000;
         tests++;
         if (press !== exp || rel !== 6'b000000) begin
            fails++;
            $display("FAIL reset_mid_repress edge %0d: press=%b rel=%b want %b/000000", k, press, rel, exp);
         end
      end
   endtask

   task automatic test_active_low();
      for (int k = 0; k < 16; k++) begin
         step();
         tests++;
         if ({level2, press2, rel2, any2} !== '0) begin
            fails++;
            $display("FAIL active_low_idle edge %0d: lvl=%b prs=%b rel=%b any=%b want 0", k, level2, press2, rel2, any2);
         end
      end
      swb2[4] = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         step();
         tests++;
         if (press2 !== ((k == 7) ? 6'b010000 : 6'b000000) || level2[4] !== (k >= 7)) begin
            fails++;
            $display("FAIL active_low_press edge %0d: press=%b level4=%b", k, press2, level2[4]);
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 6 + 5 * i) == 0) swb[i] = ~swb[i];
         end
         step();
         tests++;
         if (level !== m_lvl) begin
            fails++;
            $display("FAIL rand_level cycle %0d: got %b want %b", c, level, m_lvl);
         end
         tests++;
         if (press !== m_press || any !== (|m_press)) begin
            fails++;
            $display("FAIL rand_press cycle %0d: got %b/%b want %b/%b", c, press, any, m_press, |m_press);
         end
         tests++;
         if (rel !== m_rel) begin
            fails++;
            $display("FAIL rand_release cycle %0d: got %b want %b", c, rel, m_rel);
         end
         tests++;
         if (lng !== m_long) begin
            fails++;
            $display("FAIL rand_long cycle %0d: got %b want %b", c, lng, m_long);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_press();
      test_bounce();
      test_release();
      test_reset();
      test_simultaneous();
      test_reset();
      test_long_press();
      test_reset();
      test_reset_mid();
      test_reset();
      test_active_low();
      test_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
